// File: rtl/ats21_host_port_if.sv
// Host-side bundle for the ATS21 port: local command/response handshake,
// ATS21 request/ready/status wires and the alarm inputs and outputs.
interface ats21_host_port_if;
    logic        cmd_valid;
    logic [31:0] cmd_instr;
    logic        cmd_ready;
    logic        rsp_valid;
    logic        rsp_ack;
    logic        rsp_timeout;
    logic        req;
    logic [15:0] ctrl;
    logic        ready;
    logic [1:0]  stat;
    logic [23:0] alarm_data;
    logic [23:0] alarm_clr;
    logic [23:0] alarm_pending;

    modport master (
        output cmd_valid, cmd_instr, ready, stat, alarm_data, alarm_clr,
        input  cmd_ready, rsp_valid, rsp_ack, rsp_timeout, req, ctrl, alarm_pending
    );

    modport slave (
        input  cmd_valid, cmd_instr, ready, stat, alarm_data, alarm_clr,
        output cmd_ready, rsp_valid, rsp_ack, rsp_timeout, req, ctrl, alarm_pending
    );
endinterface

// File: rtl/ats21_host_port.sv
// ATS21 host port: sends a 32-bit instruction as two 16-bit halves with a ready
// handshake and timeout. Define ATS21_ALARM_LATCH_EN to latch alarm edges.
module ats21_host_port #(
    parameter int CLIENT  = 0,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    ats21_host_port_if.slave   bus
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("ats21_host_port: TIMEOUT must be in 1..255");
    end
    if (CLIENT != 0 && CLIENT != 1) begin : g_bad_client
        $error("ats21_host_port: CLIENT must be 0 or 1");
    end

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RDY,
        S_LO,
        S_EXEC,
        S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        ack_q, ack_d;
    logic        to_q, to_d;

    logic        cmd_ready_c;
    logic        req_c;
    logic [15:0] ctrl_c;
    logic        rsp_valid_c;
    logic        stat_sel;

    assign stat_sel = (CLIENT == 0) ? bus.stat[0] : bus.stat[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            to_q    <= to_d;
        end
    end

    // The instruction latch only carries data; state alone decides when it is shown.
    always_ff @(posedge clk) begin
        instr_q <= instr_d;
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        cnt_d       = cnt_q;
        ack_d       = ack_q;
        to_d        = to_q;
        cmd_ready_c = 1'b0;
        req_c       = 1'b0;
        ctrl_c      = 16'h0000;
        rsp_valid_c = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cmd_ready_c = 1'b1;
                if (bus.cmd_valid) begin
                    instr_d = bus.cmd_instr;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                req_c   = 1'b1;
                ctrl_c  = instr_q[31:16];
                cnt_d   = '0;
                state_d = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                ctrl_c = instr_q[31:16];
                if (bus.ready) begin
                    state_d = S_LO;
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    ack_d   = 1'b0;
                    to_d    = 1'b1;
                    state_d = S_RESP;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_LO: begin
                ctrl_c  = instr_q[15:0];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // Status is captured on the edge that enters RESP.
                ack_d   = stat_sel;
                to_d    = 1'b0;
                state_d = S_RESP;
            end
            S_RESP: begin
                rsp_valid_c = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.cmd_ready   = cmd_ready_c;
    assign bus.req         = req_c;
    assign bus.ctrl        = ctrl_c;
    assign bus.rsp_valid   = rsp_valid_c;
    assign bus.rsp_ack     = ack_q;
    assign bus.rsp_timeout = to_q;

`ifdef ATS21_ALARM_LATCH_EN
    logic [23:0] hist_q;
    logic [23:0] pend_q, pend_d;

    // A fresh rising edge beats a simultaneous clear.
    always_comb begin
        pend_d = (pend_q & ~bus.alarm_clr) | (bus.alarm_data & ~hist_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
            pend_q <= '0;
        end else begin
            hist_q <= bus.alarm_data;
            pend_q <= pend_d;
        end
    end

    assign bus.alarm_pending = pend_q;
`else
    logic [23:0] unused_alarm_clr;

    assign unused_alarm_clr  = bus.alarm_clr;
    assign bus.alarm_pending = bus.alarm_data;
`endif

endmodule

// File: tb/tb_ats21_host_port.sv
// Randomized scoreboard bench for ats21_host_port: two instances (CLIENT 0 and 1)
// share one stimulus stream; responses and per-cycle bus values come from a model.
module tb_ats21_host_port;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ats21_host_port_if bus0 ();
    ats21_host_port_if bus1 ();

    assign bus1.cmd_valid  = bus0.cmd_valid;
    assign bus1.cmd_instr  = bus0.cmd_instr;
    assign bus1.ready      = bus0.ready;
    assign bus1.stat       = bus0.stat;
    assign bus1.alarm_data = bus0.alarm_data;
    assign bus1.alarm_clr  = bus0.alarm_clr;

    ats21_host_port #(.CLIENT(0), .TIMEOUT(TO)) u_dut0 (.clk(clk), .reset(rst_n), .bus(bus0));
    ats21_host_port #(.CLIENT(1), .TIMEOUT(TO)) u_dut1 (.clk(clk), .reset(rst_n), .bus(bus1));

    typedef struct {
        int due;
        bit a0;
        bit a1;
        bit to;
    } rsp_t;

    rsp_t        rq[$];
    bit          exp_req  [int];
    logic [15:0] exp_ctrl [int];
    bit          exp_busy [int];

    int n_chk  = 0;
    int n_fail = 0;
    bit alarm_rand = 1'b0;
    bit hold_noise = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name, input string what);
        n_chk++;
        n_fail++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    // Alarm reference: each bit sets on a 0->1 of its input, else clears on its clear bit.
`ifdef ATS21_ALARM_LATCH_EN
    logic [23:0] m_pend, m_prev;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend <= '0;
            m_prev <= '0;
        end else begin
            for (int i = 0; i < 24; i++) begin
                if (bus0.alarm_data[i] && !m_prev[i])
                    m_pend[i] <= 1'b1;
                else if (bus0.alarm_clr[i])
                    m_pend[i] <= 1'b0;
            end
            m_prev <= bus0.alarm_data;
        end
    end
    function automatic logic [23:0] exp_alarm();
        return m_pend;
    endfunction
`else
    function automatic logic [23:0] exp_alarm();
        return bus0.alarm_data;
    endfunction
`endif

    // Monitor: compares every cycle away from the active edge.
    always @(negedge clk) begin
        logic [15:0] e_ctrl;
        bit          e_req, e_rdy;
        rsp_t        r;
        if (!rst_n) begin
            chk("rst_req",       32'({bus1.req, bus0.req}), 32'd0);
            chk("rst_ctrl0",     32'(bus0.ctrl), 32'd0);
            chk("rst_ctrl1",     32'(bus1.ctrl), 32'd0);
            chk("rst_rsp_valid", 32'({bus1.rsp_valid, bus0.rsp_valid}), 32'd0);
            chk("rst_rsp_ack",   32'({bus1.rsp_ack, bus0.rsp_ack}), 32'd0);
            chk("rst_rsp_to",    32'({bus1.rsp_timeout, bus0.rsp_timeout}), 32'd0);
            chk("rst_cmd_ready", 32'({bus1.cmd_ready, bus0.cmd_ready}), 32'd3);
            chk("rst_alarm",     32'(bus0.alarm_pending), 32'(exp_alarm()));
        end else begin
            e_req  = exp_req.exists(cyc);
            e_ctrl = exp_ctrl.exists(cyc) ? exp_ctrl[cyc] : 16'h0000;
            e_rdy  = !exp_busy.exists(cyc);
            chk("req0",       32'(bus0.req), 32'(e_req));
            chk("req1",       32'(bus1.req), 32'(e_req));
            chk("ctrl0",      32'(bus0.ctrl), 32'(e_ctrl));
            chk("ctrl1",      32'(bus1.ctrl), 32'(e_ctrl));
            chk("cmd_ready0", 32'(bus0.cmd_ready), 32'(e_rdy));
            chk("cmd_ready1", 32'(bus1.cmd_ready), 32'(e_rdy));
            chk("alarm0",     32'(bus0.alarm_pending), 32'(exp_alarm()));
            chk("alarm1",     32'(bus1.alarm_pending), 32'(exp_alarm()));
            if (bus0.rsp_valid || bus1.rsp_valid) begin
                if (rq.size() == 0) begin
                    fail_evt("rsp_unexpected", "rsp_valid with no outstanding command");
                end else begin
                    r = rq.pop_front();
                    chk("rsp_cycle",  32'(cyc), 32'(r.due));
                    chk("rsp_valid",  32'({bus1.rsp_valid, bus0.rsp_valid}), 32'd3);
                    chk("rsp_ack0",   32'(bus0.rsp_ack), 32'(r.a0));
                    chk("rsp_ack1",   32'(bus1.rsp_ack), 32'(r.a1));
                    chk("rsp_to0",    32'(bus0.rsp_timeout), 32'(r.to));
                    chk("rsp_to1",    32'(bus1.rsp_timeout), 32'(r.to));
                end
            end else if (rq.size() > 0 && rq[0].due < cyc) begin
                r = rq.pop_front();
                fail_evt("rsp_missing", $sformatf("no rsp_valid by cycle %0d", r.due));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (alarm_rand) begin
            bus0.alarm_data = 24'($urandom);
            bus0.alarm_clr  = 24'($urandom & $urandom & $urandom);
        end
        if (hold_noise && bus0.cmd_valid)
            bus0.cmd_instr = $urandom;
    endtask

    // Issue one command in an idle cycle. k = cycles ready is delayed after the
    // first WAIT cycle, or -1 for no ready at all. Returns in the first idle cycle.
    task automatic run_txn(input logic [31:0] instr, input logic [1:0] st,
                           input int k, input bit hold);
        int   a, due, last_hi;
        rsp_t r;
        a = cyc + 1;
        bus0.cmd_valid = 1'b1;
        bus0.cmd_instr = instr;
        bus0.stat      = st;
        bus0.ready     = 1'b0;
        if (k < 0) begin
            due     = a + 1 + TO;
            last_hi = a + TO;
        end else begin
            due     = a + 4 + k;
            last_hi = a + 1 + k;
            exp_ctrl[a + 2 + k] = instr[15:0];
        end
        exp_req[a] = 1'b1;
        for (int c = a; c <= last_hi; c++) exp_ctrl[c] = instr[31:16];
        for (int c = a; c <= due; c++) exp_busy[c] = 1'b1;
        r.due = due;
        r.a0  = (k < 0) ? 1'b0 : st[0];
        r.a1  = (k < 0) ? 1'b0 : st[1];
        r.to  = (k < 0);
        rq.push_back(r);
        hold_noise = hold;

        step();
        if (!hold) bus0.cmd_valid = 1'b0;
        bus0.ready = 1'($urandom_range(0, 1));
        step();
        bus0.ready = 1'b0;
        if (k < 0) begin
            repeat (TO) step();
        end else begin
            repeat (k) step();
            bus0.ready = 1'b1;
            step();
            repeat (2) begin
                bus0.ready = 1'($urandom_range(0, 1));
                step();
            end
        end
        bus0.stat  = 2'($urandom);
        bus0.ready = 1'($urandom_range(0, 1));
        step();
        bus0.cmd_valid = 1'b0;
        bus0.ready     = 1'b0;
        hold_noise     = 1'b0;
    endtask

    // Start a command, deliver ready immediately, then assert reset in the LO cycle.
    task automatic abort_in_lo(input logic [31:0] instr);
        int a;
        a = cyc + 1;
        bus0.cmd_valid = 1'b1;
        bus0.cmd_instr = instr;
        bus0.ready     = 1'b0;
        exp_req[a]      = 1'b1;
        exp_ctrl[a]     = instr[31:16];
        exp_ctrl[a + 1] = instr[31:16];
        exp_busy[a]     = 1'b1;
        exp_busy[a + 1] = 1'b1;
        step();
        bus0.cmd_valid = 1'b0;
        step();
        bus0.ready = 1'b1;
        step();
        bus0.ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_n           = 1'b0;
        bus0.cmd_valid  = 1'b0;
        bus0.cmd_instr  = '0;
        bus0.ready      = 1'b0;
        bus0.stat       = 2'b00;
        bus0.alarm_data = '0;
        bus0.alarm_clr  = '0;
        repeat (3) step();

        rst_n = 1'b1;
        run_txn(32'h2A40_0010, 2'b01, 0, 1'b0);
        alarm_rand = 1'b1;
        run_txn($urandom, 2'b01, -1, 1'b0);
        run_txn($urandom, 2'b11, TO - 1, 1'b0);
        run_txn($urandom, 2'b10, 0, 1'b1);
        run_txn($urandom, 2'($urandom), 3, 1'b1);
        run_txn($urandom, 2'($urandom), -1, 1'b1);

        for (int n = 0; n < 30; n++) begin
            k = int'($urandom_range(0, 19));
            if (k >= TO) k = -1;
            run_txn($urandom, 2'($urandom), k, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                bus0.ready = 1'($urandom_range(0, 1));
                step();
            end
            bus0.ready = 1'b0;
        end

        abort_in_lo($urandom);
        rst_n = 1'b1;
        run_txn($urandom, 2'($urandom), 1, 1'b0);

        alarm_rand      = 1'b0;
        bus0.alarm_data = '0;
        bus0.alarm_clr  = '1;
        step();
        bus0.alarm_clr  = '0;
        step();
        bus0.alarm_data = 24'h000020;
        step();
        bus0.alarm_data = '0;
        step();
        step();
`ifdef ATS21_ALARM_LATCH_EN
        chk("alarm_held", 32'(bus0.alarm_pending), 32'h0000_0020);
`else
        chk("alarm_follow", 32'(bus0.alarm_pending), 32'h0000_0000);
`endif
        bus0.alarm_data = 24'h000020;
        bus0.alarm_clr  = 24'h000020;
        step();
        bus0.alarm_clr  = '0;
        step();
`ifdef ATS21_ALARM_LATCH_EN
        chk("alarm_set_wins", 32'(bus0.alarm_pending), 32'h0000_0020);
`else
        chk("alarm_follow_hi", 32'(bus0.alarm_pending), 32'h0000_0020);
`endif

        repeat (4) step();
        if (rq.size() != 0)
            fail_evt("rsp_drain", $sformatf("%0d responses never arrived", rq.size()));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
